seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit 7-segment indicator. It shares the single segment bus between four digits by sequencing the digit enables, with a dead-time blanking gap between digits to prevent ghosting. A bus-side write port loads a new 4-digit hex value through a valid/ready handshake. The value is applied only at a frame boundary, so a partially updated number is never displayed.

---
 rtl/seg7_scan_ctrl_pkg.sv | 29 ++
 rtl/seg7_scan_ctrl_if.sv | 29 ++
 rtl/seg7_scan_ctrl_hex_decode.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared types and constants for the 4-digit 7-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg7_state_t;

    localparam int c_num_digits = 4;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g; entry n is hex digit n.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return c_seg_table[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Valid/ready write port carrying a 4-digit hex value and decimal points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// ============================================================================
// Module   : seg7_hex_decode
// Brief    : Combinational 4-bit hex to active-high 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
    import seg7_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : 4-digit 7-segment scan controller with dead-time blanking and
//            frame-synchronous value update. Define SEG7_SCAN_LZB_EN for
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  wire logic       clk_clk,
    input  wire logic       reset_reset_n,
    seg7_scan_ctrl_if.slave wr,
    output logic [6:0]      segment_segment,
    output logic            dp_out,
    output logic [3:0]      enable_enable
);

    localparam int                 c_cnt_w      = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(DIGIT_CYCLES - 1);
    localparam logic [1:0]         c_last_digit = 2'(c_num_digits - 1);
    localparam logic               c_inv        = (ACTIVE_LOW != 0);

    seg7_state_t        r_state;
    logic [c_cnt_w-1:0] r_slot_cnt;
    logic [1:0]         r_digit_idx;
    logic [15:0]        r_pending_data;
    logic [3:0]         r_pending_dp;
    logic               r_pending_flag;
    logic [15:0]        r_disp_data;
    logic [3:0]         r_disp_dp;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [3:0]         r_en;

    logic               w_xfer;
    logic               w_slot_end;
    logic               w_commit;
    logic [3:0]         w_nibble;
    logic [6:0]         w_dec_seg;
    logic               w_lz_blank;
    logic [6:0]         w_seg_hi;
    logic               w_dp_hi;
    logic [3:0]         w_en_hi;

    assign wr.wr_ready = ~r_pending_flag;
    assign w_xfer      = wr.wr_valid & ~r_pending_flag;
    assign w_slot_end  = (r_state == SHOW) && (r_slot_cnt == c_slot_last);
    // Only a value already pending at the frame-end edge is committed.
    assign w_commit    = w_slot_end && (r_digit_idx == c_last_digit) && r_pending_flag;
    assign w_nibble    = r_disp_data[{r_digit_idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

`ifdef SEG7_SCAN_LZB_EN
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_digit_idx)
            2'd3:    w_lz_blank = (r_disp_data[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_disp_data[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_disp_data[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_en_hi  = 4'b0000;
        w_seg_hi = 7'h00;
        w_dp_hi  = 1'b0;
        if (r_state == SHOW) begin
            w_en_hi  = 4'b0001 << r_digit_idx;
            w_seg_hi = w_lz_blank ? 7'h00 : w_dec_seg;
            w_dp_hi  = r_disp_dp[r_digit_idx];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state        <= BLANK;
            r_slot_cnt     <= '0;
            r_digit_idx    <= 2'd0;
            r_pending_data <= 16'h0000;
            r_pending_dp   <= 4'h0;
            r_pending_flag <= 1'b0;
            r_disp_data    <= 16'h0000;
            r_disp_dp      <= 4'h0;
            r_seg          <= {7{c_inv}};
            r_dp           <= c_inv;
            r_en           <= {4{c_inv}};
        end else begin
            r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;

            case (r_state)
                BLANK: begin
                    if (r_slot_cnt == c_blank_last) begin
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_slot_end) begin
                        r_state     <= BLANK;
                        r_digit_idx <= r_digit_idx + 2'd1;
                    end
                end
                default: r_state <= BLANK;
            endcase

            if (w_xfer) begin
                r_pending_data <= wr.wr_data;
                r_pending_dp   <= wr.wr_dp;
                r_pending_flag <= 1'b1;
            end else if (w_commit) begin
                r_disp_data    <= r_pending_data;
                r_disp_dp      <= r_pending_dp;
                r_pending_flag <= 1'b0;
            end

            r_seg <= w_seg_hi ^ {7{c_inv}};
            r_dp  <= w_dp_hi ^ c_inv;
            r_en  <= w_en_hi ^ {4{c_inv}};
        end
    end

    assign segment_segment = r_seg;
    assign dp_out          = r_dp;
    assign enable_enable   = r_en;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Self-checking bench for seg7_scan_ctrl (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] segment_segment;
    logic       dp_out;
    logic [3:0] enable_enable;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    typedef struct packed {
        int          frame;
        logic [15:0] data;
        logic [3:0]  dp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] cur_data = 16'h0000;
    logic [3:0]  cur_dp = 4'h0;

    seg7_scan_ctrl_if wif ();

    seg7_scan_ctrl #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .wr              (wif),
        .segment_segment (segment_segment),
        .dp_out          (dp_out),
        .enable_enable   (enable_enable)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: edge n shows the state of edge n-1.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] hex_hi(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Per-cycle output monitor; display values come from the scoreboard at frame start.
    always @(negedge clk) begin
        int          m, p, d, f;
        logic [3:0]  nib;
        logic        blank;
        logic [3:0]  e_en;
        logic [6:0]  e_seg;
        logic        e_dp;
        exp_t        e;
        if (!rst_n) begin
            cur_data = 16'h0000;
            cur_dp   = 4'h0;
        end else if (cyc >= 1) begin
            m = cyc - 1;
            p = m % 8;
            d = (m / 8) % 4;
            f = m / 32;
            if (p == 0 && d == 0) begin
                while (sb.size() > 0 && sb[0].frame <= f) begin
                    e = sb.pop_front();
                    cur_data = e.data;
                    cur_dp   = e.dp;
                end
            end
            if (p < 2) begin
                e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                nib   = cur_data[d*4 +: 4];
                blank = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
                if (d == 3) blank = (cur_data[15:12] == 4'h0);
                if (d == 2) blank = (cur_data[15:8] == 8'h00);
                if (d == 1) blank = (cur_data[15:4] == 12'h000);
`endif
                e_en  = ~(4'b0001 << d);
                e_seg = blank ? 7'h7F : ~hex_hi(nib);
                e_dp  = ~cur_dp[d];
            end
            chk("enable", {12'h000, enable_enable}, {12'h000, e_en});
            chk("segment", {9'h000, segment_segment}, {9'h000, e_seg});
            chk("dp", {15'h0000, dp_out}, {15'h0000, e_dp});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 1000) begin
            step();
            g++;
        end
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] p, output int tx);
        int waited = 0;
        tx = -1;
        wif.wr_valid = 1'b1;
        wif.wr_data  = d;
        wif.wr_dp    = p;
        while (wif.wr_ready !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (wif.wr_ready === 1'b1) begin
            tx = cyc + 1;
            step();
        end
        wif.wr_valid = 1'b0;
        wif.wr_data  = 16'($urandom);
        wif.wr_dp    = 4'($urandom);
    endtask

    initial begin
        int tx;
        wif.wr_valid = 1'b0;
        wif.wr_data  = 16'hDEAD;
        wif.wr_dp    = 4'hF;
        repeat (3) step();

        chk("rst_enable", {12'h000, enable_enable}, 16'h000F);
        chk("rst_segment", {9'h000, segment_segment}, 16'h007F);
        chk("rst_dp", {15'h0000, dp_out}, 16'h0001);
        chk("rst_ready", {15'h0000, wif.wr_ready}, 16'h0001);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {15'h0000, wif.wr_ready}, 16'h0001);

        wait_cyc(3);
        chk("first_digit0_seg", {9'h000, segment_segment}, 16'h0040);
        chk("first_digit0_en", {12'h000, enable_enable}, 16'h000E);

        // Mid-frame write: committed at edge 64, visible in frame 2.
        wait_cyc(44);
        do_write(16'h1234, 4'b0100, tx);
        chk("tx1_edge", tx[15:0], 16'd45);
        sb.push_back('{frame: 2, data: 16'h1234, dp: 4'b0100});
        chk("ready_fall1", {15'h0000, wif.wr_ready}, 16'h0000);

        // Held offer under back-pressure: accepted the edge after the commit.
        do_write(16'hABCD, 4'b1001, tx);
        chk("tx2_edge", tx[15:0], 16'd65);
        sb.push_back('{frame: 3, data: 16'hABCD, dp: 4'b1001});
        chk("ready_fall2", {15'h0000, wif.wr_ready}, 16'h0000);

        // Transfer on an empty commit edge waits a whole frame.
        wait_cyc(127);
        chk("ready_before_128", {15'h0000, wif.wr_ready}, 16'h0001);
        do_write(16'h5A0F, 4'b0010, tx);
        chk("tx3_edge", tx[15:0], 16'd128);
        sb.push_back('{frame: 5, data: 16'h5A0F, dp: 4'b0010});

        wait_cyc(170);
        do_write(16'h0040, 4'b0000, tx);
        chk("tx4_edge", tx[15:0], 16'd171);
        sb.push_back('{frame: 6, data: 16'h0040, dp: 4'b0000});

        wait_cyc(200);
        do_write(16'h0000, 4'b1010, tx);
        chk("tx5_edge", tx[15:0], 16'd201);
        sb.push_back('{frame: 7, data: 16'h0000, dp: 4'b1010});

        // Pending value must be lost on a mid-frame reset.
        wait_cyc(260);
        do_write(16'h5555, 4'b1111, tx);
        chk("tx6_edge", tx[15:0], 16'd261);
        step();
        rst_n = 1'b0;
        step();
        step();
        chk("rst2_enable", {12'h000, enable_enable}, 16'h000F);
        chk("rst2_segment", {9'h000, segment_segment}, 16'h007F);
        chk("rst2_dp", {15'h0000, dp_out}, 16'h0001);
        chk("rst2_ready", {15'h0000, wif.wr_ready}, 16'h0001);
        chk("rst2_sb_empty", 16'(sb.size()), 16'd0);
        rst_n = 1'b1;
        wait_cyc(70);
        chk("end_ready", {15'h0000, wif.wr_ready}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
